main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

Responder end of the L1 data cache ↔ main memory line-transfer handshake. It accepts a LOAD or STORE line request from `l1_dcache`, acknowledges the address, and completes the transfer. A load is a fixed-latency read burst; a store is a paced write burst. It owns the backing word array and sits under `MemorySubsystem` as the memory side of the cache refill/writeback path.

## Interface
- `ADDR_W`, 32, request address width (byte address)
- `DATA_W`, 32, word width
- `MEM_WORDS`, 1024, array depth in words (power of two)
- `LINE_WORDS`, 4, beats per line (power of two, ≥2)
- `LATENCY`, 3, idle cycles between ACK_ADDR and the first read beat (≥1)
- `CLK` in 1: single clock; all logic on rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `ADDR` in ADDR_W: line request address; sampled on accept
- `LOAD` in 1: line read request; held until ACK_ADDR is seen
- `STORE` in 1: line write request; held until ACK_ADDR is seen
- `ACK_ADDR` out 1: one-cycle pulse; request accepted
- `RDATA` out DATA_W: read beat data; valid only while READY=1
- `READY` out 1: read beat valid
- `WDATA` in DATA_W: write beat data; qualified by VALID
- `VALID` in 1: write beat present
- `ACK_DATA` out 1: one-cycle pulse per write beat committed
- `BUSY` out 1: high in every state except IDLE

## Operation
- States: IDLE, WAIT, RBURST, WBURST.
- IDLE: on an edge with LOAD=1, latch the base index. The base is `ADDR[..2]` with the low log2(LINE_WORDS) bits cleared, taken modulo MEM_WORDS. Register ACK_ADDR=1, load the latency counter with LATENCY, then go to WAIT. With STORE=1 (and LOAD=0), latch the base the same way, register ACK_ADDR=1, clear the beat counter, then go to WBURST.
- LOAD and STORE both high in IDLE: LOAD wins. STORE must stay asserted and is accepted after the load completes.
- WAIT: decrement the counter each cycle. On the edge where it reaches 0, go to RBURST with beat=0.
- RBURST: each cycle, register READY=1 and RDATA=mem[base+beat] and increment beat. After beat LINE_WORDS−1, go to IDLE and drop READY next cycle. Beats are consecutive, with no backpressure.
- WBURST: on each edge with VALID=1, write mem[base+beat]=WDATA, register ACK_DATA=1 and increment beat. VALID=0 inserts a stall, leaves the counter unchanged and produces no ACK_DATA. After beat LINE_WORDS−1, go to IDLE.
- Requests arriving outside IDLE are ignored, so no second ACK_ADDR is raised. A LOAD or STORE still high the cycle after ACK_ADDR is not re-accepted, because the FSM has already left IDLE.
- VALID in any state other than WBURST is ignored; no write and no ACK_DATA.
- Beat address is base+beat. It never crosses the line, and line index wraps modulo MEM_WORDS.
- Reset: state IDLE; ACK_ADDR, READY, ACK_DATA and BUSY are 0; RDATA is 0; counters are 0. The array is not reset. Reset mid-burst aborts the burst, and beats already written stay in the array.

## Timing
- Load accepted at edge 0:
  - ACK_ADDR is high for edges 0–1.
  - READY is high after edges LATENCY+1 … LATENCY+LINE_WORDS.
  - The next accept is possible at edge LATENCY+LINE_WORDS+1 at the earliest.
- Store accepted at edge 0: the earliest committed beat is at edge 1, and ACK_DATA follows one cycle after each committed beat. The minimum store occupancy is LINE_WORDS+1 edges.
- All outputs are registered, with no combinational input-to-output path.

## Structure
- Package `mem_if_pkg`:
  - state enum (IDLE, WAIT, RBURST, WBURST)
  - beat-counter width `$clog2(LINE_WORDS)`
  - latency-counter width
  - default LINE_WORDS and LATENCY constants
- Sub-module `mem_word_array`: MEM_WORDS×DATA_W, combinational read port, synchronous write-enable port. The FSM and all handshake registers live in `main_mem_responder`.

## Test plan
- Reset, then preload via STORE at ADDR=0x40 with beats 0xA0–0xA3 and VALID=1 continuously. Required: one ACK_ADDR, ACK_DATA on four consecutive cycles, then BUSY low.
- LOAD at ADDR=0x4C (unaligned). Required: ACK_ADDR at +1, READY high after edges 4–7, RDATA 0xA0, 0xA1, 0xA2, 0xA3 (line base 0x40).
- STORE with VALID toggling 1,0,1,1,0,1. Required: exactly 4 ACK_DATA pulses, each one cycle after its VALID beat; a reread returns the new words.
- LOAD and STORE raised together and both held. Required: load completes first, then STORE is ACKed in IDLE, with no overlap of READY and ACK_DATA.
- LOAD at ADDR=0x1000 (equal to MEM_WORDS×4). Required: returns the line at index 0.
- RST_N low after the second write beat. Required: outputs 0 immediately, state IDLE; a subsequent load shows beats 0–1 new and beats 2–3 old.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and sizing helpers for the main-memory line responder.
// Holds the FSM state enum, default geometry and counter-width functions.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST
    } state_t;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 3;

    // Width of the beat counter for a given line size.
    function automatic int beat_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Width of the latency counter; must hold LATENCY itself.
    function automatic int lat_w(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-to-memory line-transfer bus.
// master: addr/load/store/wdata/valid out; slave: acks, read beats, busy out.
interface main_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              load;
    logic              store;
    logic              ack_addr;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [DATA_W-1:0] wdata;
    logic              valid;
    logic              ack_data;
    logic              busy;

    modport master (
        output addr, load, store, wdata, valid,
        input  ack_addr, rdata, ready, ack_data, busy
    );

    modport slave (
        input  addr, load, store, wdata, valid,
        output ack_addr, rdata, ready, ack_data, busy
    );
endinterface

// File: rtl/mem_word_array.sv
// Backing word store: combinational read, synchronous write-enable.
// Ports: clk, we, addr (shared read/write index), wdata, rdata.
module mem_word_array #(
    parameter int MEM_WORDS = 1024,
    parameter int DATA_W    = 32,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for L1 line refills (fixed-latency read burst)
// and writebacks (paced write burst). Ports: clk, rst_n, bus (slave).
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    main_mem_responder_if.slave bus
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = beat_w(LINE_WORDS);
    localparam int LAT_W  = lat_w(LATENCY);
    localparam int LINE_W = IDX_W - BEAT_W;

    state_t             state, state_n;
    logic [LAT_W-1:0]   cnt, cnt_n;
    logic [BEAT_W-1:0]  beat, beat_n;
    logic [LINE_W-1:0]  line, line_n;
    logic               ack_addr, ack_addr_n;
    logic               ready, ready_n;
    logic               ack_data, ack_data_n;
    logic [DATA_W-1:0]  rdata, rdata_n;
    logic               we;
    logic [DATA_W-1:0]  rd;
    logic [LINE_W-1:0]  req_line;
    logic               last;
    logic               unused_addr;

    // Word index with the in-line offset dropped; upper bits give the
    // modulo-MEM_WORDS wrap for free.
    assign req_line = bus.addr[IDX_W+1:BEAT_W+2];
    assign unused_addr = ^{bus.addr[ADDR_W-1:IDX_W+2],
                           bus.addr[BEAT_W+1:0]};

    assign last = (beat == BEAT_W'(LINE_WORDS - 1));

    mem_word_array #(
        .MEM_WORDS(MEM_WORDS),
        .DATA_W   (DATA_W)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .addr ({line, beat}),
        .wdata(bus.wdata),
        .rdata(rd)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        beat_n     = beat;
        line_n     = line;
        ack_addr_n = 1'b0;
        ready_n    = 1'b0;
        ack_data_n = 1'b0;
        rdata_n    = rdata;
        we         = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    line_n     = req_line;
                    ack_addr_n = 1'b1;
                    cnt_n      = LAT_W'(LATENCY);
                    state_n    = WAIT;
                end else if (bus.store) begin
                    line_n     = req_line;
                    ack_addr_n = 1'b1;
                    beat_n     = '0;
                    state_n    = WBURST;
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == LAT_W'(1)) begin
                    beat_n  = '0;
                    state_n = RBURST;
                end
            end
            RBURST: begin
                ready_n = 1'b1;
                rdata_n = rd;
                beat_n  = beat + 1'b1;
                if (last) begin
                    state_n = IDLE;
                end
            end
            WBURST: begin
                if (bus.valid) begin
                    we         = 1'b1;
                    ack_data_n = 1'b1;
                    beat_n     = beat + 1'b1;
                    if (last) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            beat     <= '0;
            line     <= '0;
            ack_addr <= 1'b0;
            ready    <= 1'b0;
            ack_data <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            beat     <= beat_n;
            line     <= line_n;
            ack_addr <= ack_addr_n;
            ready    <= ready_n;
            ack_data <= ack_data_n;
            rdata    <= rdata_n;
        end
    end

    assign bus.ack_addr = ack_addr;
    assign bus.ready    = ready;
    assign bus.ack_data = ack_data;
    assign bus.rdata    = rdata;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed plus randomized bench for main_mem_responder.
// Reference: word array plus cycle timing derived from the handshake rules.
module tb_main_mem_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 1024;
    localparam int LW  = 4;
    localparam int LAT = 3;

    logic clk;
    logic rst_n;

    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    main_mem_responder #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_WORDS (MW),
        .LINE_WORDS(LW),
        .LATENCY   (LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic [31:0] ref_mem [MW];
    bit written [MW/LW];
    int wq[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line number of a byte address, wrapped to the array.
    function automatic int line_of(input logic [31:0] a);
        return int'(((a / 4) / LW) % (MW / LW));
    endfunction

    task automatic note_line(input int ln);
        if (!written[ln]) begin
            written[ln] = 1'b1;
            wq.push_back(ln);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input bit hold_store);
        int ln;
        ln = line_of(a);
        bus.addr  = a;
        bus.load  = 1'b1;
        bus.store = hold_store;
        bus.valid = 1'($urandom);
        bus.wdata = $urandom;
        step();
        chk("ld_ack", {31'd0, bus.ack_addr}, 32'd1);
        chk("ld_busy", {31'd0, bus.busy}, 32'd1);
        bus.load = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            bus.valid = 1'($urandom);
            bus.wdata = $urandom;
            step();
            chk("ld_wait_rdy", {31'd0, bus.ready}, 32'd0);
            chk("ld_wait_ack", {31'd0, bus.ack_addr}, 32'd0);
            chk("ld_wait_ackd", {31'd0, bus.ack_data}, 32'd0);
        end
        for (int b = 0; b < LW; b++) begin
            bus.valid = 1'($urandom);
            bus.wdata = $urandom;
            step();
            chk("ld_rdy", {31'd0, bus.ready}, 32'd1);
            chk("ld_data", bus.rdata, ref_mem[ln*LW+b]);
            chk("ld_ackd", {31'd0, bus.ack_data}, 32'd0);
            chk("ld_ack2", {31'd0, bus.ack_addr}, 32'd0);
        end
        bus.valid = 1'b0;
        step();
        chk("ld_end_rdy", {31'd0, bus.ready}, 32'd0);
        if (hold_store) begin
            chk("ld_then_st_ack", {31'd0, bus.ack_addr}, 32'd1);
            chk("ld_then_st_busy", {31'd0, bus.busy}, 32'd1);
            bus.store = 1'b0;
        end else begin
            chk("ld_end_busy", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    // vmode: 0 valid always, 1 pattern then always, 2 random.
    task automatic store_burst(input int ln, input int vmode,
                               input logic [15:0] pat, input int npat,
                               input logic [31:0] d0, input bit seq);
        int beats;
        int c;
        logic v;
        logic [31:0] d;
        beats = 0;
        c = 0;
        while (beats < LW && c < 64) begin
            if (vmode == 1 && c < npat) v = pat[c];
            else if (vmode == 2) v = 1'($urandom);
            else v = 1'b1;
            d = seq ? d0 + 32'(beats) : $urandom;
            bus.valid = v;
            bus.wdata = d;
            step();
            chk("st_ackd", {31'd0, bus.ack_data}, {31'd0, v});
            chk("st_ack_addr", {31'd0, bus.ack_addr}, 32'd0);
            chk("st_rdy", {31'd0, bus.ready}, 32'd0);
            if (v) begin
                ref_mem[ln*LW+beats] = d;
                beats++;
            end
            c++;
        end
        bus.valid = 1'b0;
        chk("st_beats", 32'(beats), 32'(LW));
        chk("st_end_busy", {31'd0, bus.busy}, 32'd0);
        note_line(ln);
    endtask

    task automatic do_store(input logic [31:0] a, input int vmode,
                            input logic [15:0] pat, input int npat,
                            input logic [31:0] d0, input bit seq);
        bus.addr  = a;
        bus.store = 1'b1;
        bus.valid = 1'b0;
        step();
        chk("st_ack", {31'd0, bus.ack_addr}, 32'd1);
        chk("st_busy", {31'd0, bus.busy}, 32'd1);
        bus.store = 1'b0;
        store_burst(line_of(a), vmode, pat, npat, d0, seq);
    endtask

    initial begin
        logic [31:0] a;
        int ln;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.addr  = '0;
        bus.load  = 1'b0;
        bus.store = 1'b0;
        bus.wdata = '0;
        bus.valid = 1'b0;
        repeat (3) step();
        chk("rst_ack", {31'd0, bus.ack_addr}, 32'd0);
        chk("rst_rdy", {31'd0, bus.ready}, 32'd0);
        chk("rst_ackd", {31'd0, bus.ack_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Preload line 0x40 and line 0.
        do_store(32'h40, 0, 16'h0, 0, 32'hA0, 1'b1);
        do_store(32'h0, 0, 16'h0, 0, 32'h0, 1'b0);

        // Unaligned load returns the 0x40 line.
        do_load(32'h4C, 1'b0);

        // Stalled store, then reread.
        do_store(32'h40, 1, 16'b101101, 6, 32'h0, 1'b0);
        do_load(32'h40, 1'b0);

        // LOAD and STORE together: load first, then store accepted.
        do_load(32'h44, 1'b1);
        store_burst(line_of(32'h44), 0, 16'h0, 0, 32'hB0, 1'b1);
        do_load(32'h40, 1'b0);

        // Address at MEM_WORDS*4 wraps to line 0.
        do_load(32'h1000, 1'b0);

        // Reset after the second committed write beat.
        bus.addr  = 32'h40;
        bus.store = 1'b1;
        step();
        chk("rs_ack", {31'd0, bus.ack_addr}, 32'd1);
        bus.store = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.valid = 1'b1;
            bus.wdata = 32'hC0 + 32'(b);
            step();
            chk("rs_ackd", {31'd0, bus.ack_data}, 32'd1);
            ref_mem[line_of(32'h40)*LW+b] = 32'hC0 + 32'(b);
        end
        bus.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rs_ackd0", {31'd0, bus.ack_data}, 32'd0);
        chk("rs_busy0", {31'd0, bus.busy}, 32'd0);
        chk("rs_rdy0", {31'd0, bus.ready}, 32'd0);
        chk("rs_rdata0", bus.rdata, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        do_load(32'h40, 1'b0);

        // Randomized mix against the reference array.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                ln = wq[$urandom_range(0, wq.size() - 1)];
                a = 32'(((ln * LW) + $urandom_range(0, LW - 1)) * 4)
                    + 32'($urandom_range(0, 3))
                    + 32'($urandom_range(0, 3) * MW * 4);
                do_load(a, 1'b0);
            end else begin
                a = $urandom;
                do_store(a, 2, 16'h0, 0, 32'h0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
